// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 8-digit scan driver.
// Holds the digit count, digit index width, default timing parameters,
// the display image record and the anode-pattern helper.
package seg_scan_driver_pkg;

   localparam int NUM_DIGITS       = 8;
   localparam int IDX_W            = 3;
   localparam int DEF_SCAN_DIV     = 50000;
   localparam int DEF_BLANK_CYC    = 500;
   localparam int DEF_FLASH_FRAMES = 64;

   // One complete display image: nibble, point, blank and flash-select per digit.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   point;
      logic [NUM_DIGITS-1:0]   le;
      logic [NUM_DIGITS-1:0]   flash;
   } image_t;

   // Active-low one-hot anode pattern for digit i.
   function automatic logic [NUM_DIGITS-1:0] digit_an(input logic [IDX_W-1:0] i);
      return ~(NUM_DIGITS'(1) << i);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-MOD counter with a tick output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable
//   count      : current value, 0..MOD-1
//   tick       : high while en is set and count is at MOD-1 (the wrap cycle)
module scan_prescaler
   import seg_scan_driver_pkg::*;
#(
   parameter int MOD = 4,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tick
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   always_comb tick = en && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  count <= '0;
      else if (en) count <= tick ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit display.
// Selects one digit at a time for SCAN_DIV cycles, blanking all anodes for
// the first BLANK_CYC cycles of each digit to hide ghosting. Images arrive
// over a valid/ready handshake into a pending register and are promoted to
// the shadow register only at the frame boundary, so a frame is never torn.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   upd_valid/ready  : image handshake
//   upd_data         : eight nibbles, digit k = bits [4k+3:4k]
//   upd_point/le/flash : per-digit point, blank request, flash select
//   hex, point, le   : fields of the selected digit
//   flash            : flash gate (downstream blanks when le && flash)
//   an               : active-low anodes, registered
//   frame_start      : one-cycle pulse as the index wraps 7->0
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLANK_CYC    = DEF_BLANK_CYC,
   parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_data,
   input  logic [NUM_DIGITS-1:0]   upd_point,
   input  logic [NUM_DIGITS-1:0]   upd_le,
   input  logic [NUM_DIGITS-1:0]   upd_flash,
   output logic [3:0]              hex,
   output logic                    point,
   output logic                    le,
   output logic                    flash,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [PW-1:0]    BLANK_LIM = PW'(BLANK_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

   logic [PW-1:0]    pre_cnt, pre_nxt;
   logic             tick;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             boundary;
   logic [FW-1:0]    frm_count_unused;  // frame position isn't needed outside the counter
   logic             frm_tick;
   logic             flash_phase;
   image_t           pend, shadow;
   logic             pend_full;
   logic             xfer;

   // ---------------------------------------------------------------- timing
   scan_prescaler #(.MOD(SCAN_DIV), .W(PW)) u_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .count (pre_cnt),
      .tick  (tick)
   );

   // Frame counter advances once per frame_start; its wrap flips the flash phase.
   scan_prescaler #(.MOD(FLASH_FRAMES), .W(FW)) u_frm (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (frame_start),
      .count (frm_count_unused),
      .tick  (frm_tick)
   );

   always_comb begin
      pre_nxt  = tick ? '0 : pre_cnt + 1'b1;
      idx_nxt  = tick ? idx + 1'b1 : idx;
      boundary = tick && (idx == LAST_IDX);
   end

   // an is computed from next-state values so the registered output lines up
   // with the prescaler/index it describes, with no combinational decode on the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         an          <= '1;
         frame_start <= 1'b0;
         flash_phase <= 1'b1;
      end else begin
         idx         <= idx_nxt;
         an          <= (pre_nxt < BLANK_LIM) ? '1 : digit_an(idx_nxt);
         frame_start <= boundary;
         if (frm_tick) flash_phase <= ~flash_phase;
      end
   end

   // ------------------------------------------------------------- handshake
   // pending full <-> not ready. A transfer needs an empty pending register and
   // a copy needs a full one, so both never act on pending in the same cycle.
   assign upd_ready = ~pend_full;
   assign xfer      = upd_valid && upd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend         <= '0;
         pend_full    <= 1'b0;
         shadow.data  <= '0;
         shadow.point <= '0;
         shadow.le    <= '1;
         shadow.flash <= '0;
      end else begin
         if (boundary && pend_full) begin
            shadow    <= pend;
            pend_full <= 1'b0;
         end
         if (xfer) begin
            pend.data  <= upd_data;
            pend.point <= upd_point;
            pend.le    <= upd_le;
            pend.flash <= upd_flash;
            pend_full  <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------------- outputs
   // Shadow only changes together with idx (at the 7->0 wrap), so these fields
   // move only on index changes.
   always_comb begin
      hex   = shadow.data[{idx, 2'b00} +: 4];
      point = shadow.point[idx];
      le    = shadow.le[idx];
      flash = shadow.flash[idx] ? flash_phase : 1'b1;
   end

endmodule
